// File: rtl/memory_interface.sv
// memory_interface: 16-bit CPU bus to external 16-bit SRAM bridge. It holds a word
//   address and a data word, and runs single read/write transactions with
//   optional address post-increment.
// Latency: a request sampled at edge n raises the strobe after n. With mem_ready
//   at n+1 the data and address update at n+1, and the next request can be taken at n+2.
// Backpressure: mem_ready stalls the strobe for up to TIMEOUT cycles, then the
//   transaction aborts with a sticky err. Requests arriving while busy are dropped.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   notLoad           active-low address load from in[15:1]
//   rd_req, wr_req    start read / write (write data from in; write has priority)
//   inc               post-increment the address on successful completion
//   notOE, in, out    bus input, tri-state bus output of the data register
//   busy, err         transaction in progress, sticky timeout flag
//   mem_*             SRAM address, write data, read data, strobes, ready
module memory_interface #(
  parameter int TIMEOUT = 15  // legal range 1..255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        notLoad,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic        inc,
  input  logic        notOE,
  input  logic [15:0] in,
  output logic [15:0] out,
  output logic        busy,
  output logic        err,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  // The last count value before an abort. cnt counts the completed wait cycles.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [14:0] addr, addr_nx;
  logic [15:0] data, data_nx;
  logic [7:0]  cnt, cnt_nx;
  logic        inc_q, inc_nx;
  logic        err_q, err_nx;

  // State register. The reset clears everything. The strobes are decoded from
  // the state, so they drop at the reset edge, and nothing is captured on that edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      addr  <= '0;
      data  <= '0;
      cnt   <= '0;
      inc_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      addr  <= addr_nx;
      data  <= data_nx;
      cnt   <= cnt_nx;
      inc_q <= inc_nx;
      err_q <= err_nx;
    end
  end

  // Next-state and register updates.
  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    data_nx  = data;
    cnt_nx   = cnt;
    inc_nx   = inc_q;
    err_nx   = err_q;

    unique case (state)
      IDLE: begin
        if (!notLoad) begin
          addr_nx = in[15:1];
        end
        // While notLoad is low, the bus carries an address, not write data.
        // A write is therefore only accepted when notLoad is high. A read can
        // share the edge with a load and uses the new address, because
        // mem_addr follows addr from the next cycle.
        if (wr_req && notLoad) begin
          data_nx  = in;
          inc_nx   = inc;
          cnt_nx   = '0;
          err_nx   = 1'b0;
          state_nx = WR;
        end else if (rd_req) begin
          inc_nx   = inc;
          cnt_nx   = '0;
          err_nx   = 1'b0;
          state_nx = RD;
        end
      end

      RD, WR: begin
        // If ready arrives on the same edge as the timeout, ready takes precedence.
        if (mem_ready) begin
          if (state == RD) begin
            data_nx = mem_rdata;
          end
          if (inc_q) begin
            addr_nx = addr + 15'd1;  // natural 15-bit wrap
          end
          state_nx = IDLE;
        end else if (cnt == CNT_LAST) begin
          err_nx = 1'b1;
          if (state == RD) begin
            data_nx = 16'hFFFF;
          end
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Strobes and busy are pure decodes of the state, so they are glitch-free
  // registered outputs.
  always_comb begin
    busy   = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    unique case (state)
      RD: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
      end
      WR: begin
        busy   = 1'b1;
        mem_wr = 1'b1;
      end
      default: begin
        busy   = 1'b0;
      end
    endcase
  end

  assign err       = err_q;
  assign mem_addr  = addr;
  assign mem_wdata = data;

  // The output enable is independent of state, so the data register can be
  // driven onto the bus even mid-transaction.
  assign out = notOE ? 16'hzzzz : data;

endmodule
